// File: rtl/risac_pkg.sv
// Shared encodings for the risac memory arbiter: FSM states, grant owner and
// the byte-enable pattern used for instruction fetches.
package risac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // Fetches are always full-word; truncated to DW/8 at the use site.
    localparam logic [31:0] IBUS_BYTE_EN = 32'hFFFF_FFFF;

endpackage

// File: rtl/risac_mem_arbiter_if.sv
// Core-side (Ibus/Dbus) and memory-side signals of the risac memory arbiter.
// slave = arbiter view, master = environment (core + memory) view.
interface risac_mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned BEW = DW / 8;

    logic [AW-1:0]  iIbusAddr;
    logic           iIbusRead;
    logic [DW-1:0]  oIbusData;
    logic [AW-1:0]  oIbusIAddr;
    logic           oIbusWait;

    logic [AW-1:0]  iDbusAddr;
    logic           iDbusRead;
    logic           iDbusWe;
    logic [DW-1:0]  iDbusData;
    logic [BEW-1:0] iDbusByteEn;
    logic [DW-1:0]  oDbusData;
    logic           oDbusWait;

    logic [AW-1:0]  oMemAddr;
    logic [DW-1:0]  oMemWriteData;
    logic [BEW-1:0] oMemByteEn;
    logic           oMemRead;
    logic           oMemWrite;
    logic           iMemWait;
    logic [DW-1:0]  iMemReadData;
    logic           iMemReadValid;

    modport slave (
        input  iIbusAddr, iIbusRead,
        output oIbusData, oIbusIAddr, oIbusWait,
        input  iDbusAddr, iDbusRead, iDbusWe, iDbusData, iDbusByteEn,
        output oDbusData, oDbusWait,
        output oMemAddr, oMemWriteData, oMemByteEn, oMemRead, oMemWrite,
        input  iMemWait, iMemReadData, iMemReadValid
    );

    modport master (
        output iIbusAddr, iIbusRead,
        input  oIbusData, oIbusIAddr, oIbusWait,
        output iDbusAddr, iDbusRead, iDbusWe, iDbusData, iDbusByteEn,
        input  oDbusData, oDbusWait,
        input  oMemAddr, oMemWriteData, oMemByteEn, oMemRead, oMemWrite,
        output iMemWait, iMemReadData, iMemReadValid
    );

endinterface

// File: rtl/risac_arb_pick.sv
// Combinational requester selection for the risac memory arbiter.
// RISAC_ARB_RR_EN: alternate I/D on contention; otherwise Dbus has fixed priority.
module risac_arb_pick
    import risac_pkg::*;
(
    input  logic   i_ireq,
    input  logic   i_dreq,
    input  grant_e i_last,
    output grant_e o_grant
);

`ifndef RISAC_ARB_RR_EN
    logic w_unused_last;
    assign w_unused_last = (i_last == GRANT_D);
`endif

    always_comb begin
        o_grant = GRANT_I;
        if (i_ireq && i_dreq) begin
`ifdef RISAC_ARB_RR_EN
            o_grant = (i_last == GRANT_I) ? GRANT_D : GRANT_I;
`else
            o_grant = GRANT_D;
`endif
        end else if (i_dreq) begin
            o_grant = GRANT_D;
        end
    end

endmodule

// File: rtl/risac_mem_arbiter.sv
// Shares one single-outstanding memory port between the risac Ibus and Dbus.
// Contention policy selected by RISAC_ARB_RR_EN (see risac_arb_pick).
module risac_mem_arbiter
    import risac_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    risac_mem_arbiter_if.slave  bus
);

    localparam int unsigned BEW = DW / 8;

    state_e         r_state;
    state_e         w_state_n;
    grant_e         r_grant;
    grant_e         r_last;
    grant_e         w_pick;
    logic           r_is_wr;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_wdata;
    logic [BEW-1:0] r_be;
    logic [DW-1:0]  r_data;
    logic           r_mem_rd;
    logic           r_mem_wr;
    logic           r_ibus_wait;
    logic           r_dbus_dlv;

    logic           w_ireq;
    logic           w_dreq;
    logic           w_latch;
    logic           w_cap;
    logic           w_wr_n;
    logic           w_cmd_wr;

    assign w_ireq = bus.iIbusRead;
    assign w_dreq = bus.iDbusRead | bus.iDbusWe;

    risac_arb_pick u_pick (
        .i_ireq  (w_ireq),
        .i_dreq  (w_dreq),
        .i_last  (r_last),
        .o_grant (w_pick)
    );

    // Next-state and latch/capture strobes
    always_comb begin
        w_state_n = r_state;
        w_latch   = 1'b0;
        w_cap     = 1'b0;
        w_wr_n    = (w_pick == GRANT_D) && bus.iDbusWe;
        case (r_state)
            IDLE: begin
                if (w_ireq || w_dreq) begin
                    w_latch   = 1'b1;
                    w_state_n = CMD;
                end
            end
            CMD: begin
                if (!bus.iMemWait) begin
                    w_state_n = r_is_wr ? DONE : RESP;
                end
            end
            RESP: begin
                if (bus.iMemReadValid) begin
                    w_cap     = 1'b1;
                    w_state_n = DONE;
                end
            end
            DONE:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
        w_cmd_wr = w_latch ? w_wr_n : r_is_wr;
    end

    // State, latched command, read data and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= GRANT_I;
            r_last      <= GRANT_I;
            r_is_wr     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_data      <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_ibus_wait <= 1'b1;
            r_dbus_dlv  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_latch) begin
                r_grant <= w_pick;
                r_is_wr <= w_wr_n;
                if (w_pick == GRANT_D) begin
                    r_addr  <= bus.iDbusAddr;
                    r_wdata <= bus.iDbusData;
                    r_be    <= bus.iDbusByteEn;
                end else begin
                    r_addr  <= bus.iIbusAddr;
                    r_wdata <= '0;
                    r_be    <= BEW'(IBUS_BYTE_EN);
                end
            end
            if (w_cap) begin
                r_data <= bus.iMemReadData;
            end
            if (r_state == DONE) begin
                r_last <= r_grant;
            end
            r_mem_rd    <= (w_state_n == CMD) && !w_cmd_wr;
            r_mem_wr    <= (w_state_n == CMD) && w_cmd_wr;
            r_ibus_wait <= !((w_state_n == DONE) && (r_grant == GRANT_I));
            r_dbus_dlv  <= (w_state_n == DONE) && (r_grant == GRANT_D);
        end
    end

    assign bus.oMemAddr      = r_addr;
    assign bus.oMemWriteData = r_wdata;
    assign bus.oMemByteEn    = r_be;
    assign bus.oMemRead      = r_mem_rd;
    assign bus.oMemWrite     = r_mem_wr;
    assign bus.oIbusData     = r_data;
    assign bus.oDbusData     = r_data;
    assign bus.oIbusIAddr    = r_addr;
    assign bus.oIbusWait     = r_ibus_wait;
    // Wait only matters while the Dbus is actually asking
    assign bus.oDbusWait     = w_dreq & ~r_dbus_dlv;

endmodule

// File: tb/tb_risac_mem_arbiter.sv
// Randomized bench for risac_mem_arbiter against a transaction-level model.
// The model honours RISAC_ARB_RR_EN the same way the build does.
module tb_risac_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = DW / 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    risac_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    risac_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model state: last winner, delivered data, last latched address
    bit             m_last_d;
    logic [DW-1:0]  m_data;
    logic [AW-1:0]  m_addr;

    // Pending core requests
    bit             ip;
    logic [AW-1:0]  ia;
    bit             dp;
    bit             dwe;
    bit             dboth;
    logic [AW-1:0]  da;
    logic [DW-1:0]  dd;
    logic [BEW-1:0] dbe;

    task automatic drive_reqs();
        bus.iIbusRead   = ip;
        bus.iIbusAddr   = ia;
        bus.iDbusRead   = dp && (!dwe || dboth);
        bus.iDbusWe     = dp && dwe;
        bus.iDbusAddr   = da;
        bus.iDbusData   = dd;
        bus.iDbusByteEn = dbe;
    endtask

    task automatic model_reset();
        m_last_d = 1'b0;
        m_data   = '0;
        m_addr   = '0;
    endtask

    // One arbitration slot starting at an IDLE cycle; w = memory wait cycles,
    // v = RESP cycles without valid, stray = junk valid outside RESP.
    task automatic do_txn(input int w, input int v, input logic [DW-1:0] rdata, input bit stray);
        bit            gd;
        bit            wr;
        bit            in_cmd;
        bit            in_resp;
        bit            dlv;
        int            dl;
        logic [AW-1:0] a;

        @(negedge clk);
        check_eq("idle_rd", 64'(bus.oMemRead), 64'(0));
        check_eq("idle_wr", 64'(bus.oMemWrite), 64'(0));
        check_eq("idle_iwait", 64'(bus.oIbusWait), 64'(1));
        check_eq("idle_data", 64'(bus.oDbusData), 64'(m_data));
        drive_reqs();
        bus.iMemWait      = 1'($urandom_range(0, 1));
        bus.iMemReadValid = stray;
        bus.iMemReadData  = 32'h0000_1234;
        if (!ip && !dp) return;

`ifdef RISAC_ARB_RR_EN
        gd = dp && (!ip || !m_last_d);
`else
        gd = dp;
`endif
        wr = gd && dwe;
        a  = gd ? da : ia;
        dl = wr ? 2 + w : 3 + w + v;

        for (int c = 1; c <= dl; c++) begin
            @(negedge clk);
            in_cmd  = (c <= 1 + w);
            in_resp = !wr && (c >= 2 + w) && (c <= 2 + w + v);
            dlv     = (c == dl);
            check_eq("mem_read", 64'(bus.oMemRead), 64'(in_cmd && !wr));
            check_eq("mem_write", 64'(bus.oMemWrite), 64'(in_cmd && wr));
            if (in_cmd) begin
                check_eq("mem_addr", 64'(bus.oMemAddr), 64'(a));
                check_eq("mem_be", 64'(bus.oMemByteEn), 64'(gd ? dbe : {BEW{1'b1}}));
                if (wr) check_eq("mem_wdata", 64'(bus.oMemWriteData), 64'(dd));
            end
            check_eq("ibus_wait", 64'(bus.oIbusWait), 64'(!(dlv && !gd)));
            check_eq("dbus_wait", 64'(bus.oDbusWait), 64'(dp && !(dlv && gd)));
            if (dlv && !wr) m_data = rdata;
            check_eq("ibus_data", 64'(bus.oIbusData), 64'(m_data));
            check_eq("dbus_data", 64'(bus.oDbusData), 64'(m_data));
            check_eq("ibus_iaddr", 64'(bus.oIbusIAddr), 64'(a));

            bus.iMemWait = in_cmd ? (c <= w) : 1'($urandom_range(0, 1));
            if (!wr && c == 2 + w + v) begin
                bus.iMemReadValid = 1'b1;
                bus.iMemReadData  = rdata;
            end else if (stray && !in_resp) begin
                bus.iMemReadValid = 1'b1;
                bus.iMemReadData  = 32'h0000_1234;
            end else begin
                bus.iMemReadValid = 1'b0;
                bus.iMemReadData  = $urandom;
            end
        end

        m_addr   = a;
        m_last_d = gd;
        if (gd) dp = 1'b0;
        else    ip = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ip = 0; ia = '0; dp = 0; dwe = 0; dboth = 0; da = '0; dd = '0; dbe = '0;
        drive_reqs();
        bus.iMemWait      = 1'b0;
        bus.iMemReadValid = 1'b0;
        bus.iMemReadData  = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check_eq("rst_rd", 64'(bus.oMemRead), 64'(0));
        check_eq("rst_wr", 64'(bus.oMemWrite), 64'(0));
        check_eq("rst_addr", 64'(bus.oMemAddr), 64'(0));
        check_eq("rst_wdata", 64'(bus.oMemWriteData), 64'(0));
        check_eq("rst_be", 64'(bus.oMemByteEn), 64'(0));
        check_eq("rst_data", 64'(bus.oIbusData), 64'(0));
        check_eq("rst_iaddr", 64'(bus.oIbusIAddr), 64'(0));
        check_eq("rst_iwait", 64'(bus.oIbusWait), 64'(1));
        check_eq("rst_dwait", 64'(bus.oDbusWait), 64'(0));
        rst = 1'b0;

        // Ibus fetch, zero wait
        ip = 1; ia = 32'h0000_0100;
        do_txn(0, 0, 32'h00A0_0093, 1'b0);

        // Dbus store with two memory wait cycles
        dp = 1; dwe = 1; dboth = 0; da = 32'h0000_0200; dd = 32'hDEAD_BEEF; dbe = 4'b0011;
        do_txn(2, 0, 32'h0, 1'b0);

        // Continuous contention
        for (int k = 0; k < 4; k++) begin
            if (!ip) begin ip = 1; ia = 32'h0000_1000 + 32'(k * 4); end
            if (!dp) begin dp = 1; dwe = 0; da = 32'h0000_2000 + 32'(k * 4); dbe = 4'hF; end
            do_txn(0, 0, $urandom, 1'b0);
        end
        while (ip || dp) do_txn(0, 1, $urandom, 1'b0);

        // Stray valids in IDLE and CMD
        do_txn(0, 0, 32'h0, 1'b1);
        dp = 1; dwe = 1; dboth = 1; da = 32'h0000_0040; dd = 32'h1111_2222; dbe = 4'b1100;
        do_txn(3, 0, 32'h0, 1'b1);

        // Reset while waiting for read data
        ip = 1; ia = 32'h0000_0300;
        @(negedge clk);
        drive_reqs();
        bus.iMemWait = 1'b0; bus.iMemReadValid = 1'b0;
        @(negedge clk);
        check_eq("rr_cmd_rd", 64'(bus.oMemRead), 64'(1));
        @(negedge clk);
        rst = 1'b1; ip = 0; drive_reqs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus.iMemReadValid = 1'b1; bus.iMemReadData = 32'h5555_AAAA;
        for (int k = 0; k < 2; k++) begin
            check_eq("rr_rd", 64'(bus.oMemRead), 64'(0));
            check_eq("rr_wr", 64'(bus.oMemWrite), 64'(0));
            check_eq("rr_iwait", 64'(bus.oIbusWait), 64'(1));
            check_eq("rr_dwait", 64'(bus.oDbusWait), 64'(0));
            check_eq("rr_data", 64'(bus.oIbusData), 64'(0));
            @(negedge clk);
        end
        bus.iMemReadValid = 1'b0;

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1; ia = AW'($urandom) & ~AW'(3);
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; dwe = 1'($urandom_range(0, 1)); dboth = 1'($urandom_range(0, 1));
                da = AW'($urandom); dd = DW'($urandom); dbe = BEW'($urandom);
            end
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), DW'($urandom),
                   $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
